// File: rtl/alu_result_buffer_pkg.sv
// Shared types for the execute->memory result buffer: memory access size,
// the buffered entry layout, and the load/store alignment rule.
package alu_result_buffer_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            we;
    logic            is_load;
    logic            is_store;
    mem_size_e       size;
    logic [XLEN-1:0] store_data;
    logic            misaligned;
  } ex_entry_t;

  // An access faults when its address is not a multiple of its size.
  function automatic logic addr_misaligned(mem_size_e size, logic [2:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (size)
      MEM_B:   fault = 1'b0;
      MEM_H:   fault = addr_lo[0];
      MEM_W:   fault = |addr_lo[1:0];
      default: fault = |addr_lo;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Upstream (ALU), downstream (memory stage), flush and redirect signals of the
// result buffer. The buffer uses the slave view; its environment the master view.
interface alu_result_buffer_if;

  logic                                flush;
  logic                                in_valid;
  logic                                in_ready;
  logic [alu_result_buffer_pkg::XLEN-1:0] in_result;
  logic [4:0]                          in_rd;
  logic                                in_writes_rd;
  logic                                in_is_load;
  logic                                in_is_store;
  logic [1:0]                          in_mem_size;
  logic [alu_result_buffer_pkg::XLEN-1:0] in_store_data;
  logic                                in_is_branch;
  logic                                in_taken;
  logic [alu_result_buffer_pkg::XLEN-1:0] in_target;
  logic                                out_valid;
  logic                                out_ready;
  logic [alu_result_buffer_pkg::XLEN-1:0] out_result;
  logic [4:0]                          out_rd;
  logic                                out_we;
  logic                                out_is_load;
  logic                                out_is_store;
  logic [1:0]                          out_mem_size;
  logic [alu_result_buffer_pkg::XLEN-1:0] out_store_data;
  logic                                out_misaligned;
  logic                                redirect_valid;
  logic [alu_result_buffer_pkg::XLEN-1:0] redirect_target;

  modport slave (
    input  flush, in_valid, in_result, in_rd, in_writes_rd, in_is_load, in_is_store,
           in_mem_size, in_store_data, in_is_branch, in_taken, in_target, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we, out_is_load, out_is_store,
           out_mem_size, out_store_data, out_misaligned, redirect_valid, redirect_target
  );

  modport master (
    output flush, in_valid, in_result, in_rd, in_writes_rd, in_is_load, in_is_store,
           in_mem_size, in_store_data, in_is_branch, in_taken, in_target, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we, out_is_load, out_is_store,
           out_mem_size, out_store_data, out_misaligned, redirect_valid, redirect_target
  );

endinterface

// File: rtl/alu_result_buffer_result_fifo.sv
// DEPTH-entry FIFO of ex_entry_t with flush. Pointers wrap naturally because
// DEPTH is a power of two; count distinguishes full from empty.
module alu_result_buffer_result_fifo
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush_i,
  input  logic      push_i,
  input  ex_entry_t push_data_i,
  input  logic      pop_i,
  output ex_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ex_entry_t              entries_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = entries_q[rd_ptr_q];

  // Next pointer/count: flush clears everything, otherwise advance on push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates visibility, and the outputs are masked when empty.
    if (do_push) entries_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Execute->memory stage buffer: packs ALU result and sideband into an entry,
// flags misaligned loads/stores, queues entries, and pulses a branch redirect.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  alu_result_buffer_if.slave bus
);

  ex_entry_t       entry_in, head, head_vis;
  logic            full, empty;
  logic            accept, enqueue, pop, fault;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_target_q, redirect_target_d;

  // in_ready looks only at occupancy and flush, never at out_ready.
  assign bus.in_ready = !full && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign enqueue      = accept && (bus.in_writes_rd || bus.in_is_load || bus.in_is_store);
  assign pop          = !empty && bus.out_ready;
  assign fault        = (bus.in_is_load || bus.in_is_store)
                        && addr_misaligned(mem_size_e'(bus.in_mem_size), bus.in_result[2:0]);

  // Entry packing: a faulting access is kept but stripped of its memory op and writeback.
  always_comb begin
    entry_in            = '0;
    entry_in.result     = bus.in_result;
    entry_in.rd         = bus.in_rd;
    entry_in.we         = bus.in_writes_rd && (bus.in_rd != 5'd0) && !fault;
    entry_in.is_load    = bus.in_is_load && !fault;
    entry_in.is_store   = bus.in_is_store && !fault;
    entry_in.size       = mem_size_e'(bus.in_mem_size);
    entry_in.store_data = bus.in_store_data;
    entry_in.misaligned = fault;
  end

  alu_result_buffer_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (bus.flush),
    .push_i      (enqueue),
    .push_data_i (entry_in),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Head is presented as all zeros while the buffer is empty.
  assign head_vis           = empty ? '0 : head;
  assign bus.out_valid      = !empty;
  assign bus.out_result     = head_vis.result;
  assign bus.out_rd         = head_vis.rd;
  assign bus.out_we         = head_vis.we;
  assign bus.out_is_load    = head_vis.is_load;
  assign bus.out_is_store   = head_vis.is_store;
  assign bus.out_mem_size   = head_vis.size;
  assign bus.out_store_data = head_vis.store_data;
  assign bus.out_misaligned = head_vis.misaligned;

  // Redirect next state: pulse for one cycle per accepted taken branch, target sticks.
  always_comb begin
    redirect_valid_d  = accept && bus.in_is_branch && bus.in_taken;
    redirect_target_d = redirect_valid_d ? bus.in_target : redirect_target_q;
  end

  // Redirect registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else begin
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
    end
  end

  assign bus.redirect_valid  = redirect_valid_q;
  assign bus.redirect_target = redirect_target_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_result_buffer_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_buffer_if bus();

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic [63:0] store_data;
    logic        mis;
  } model_t;

  model_t      mq[$];
  logic        m_rv;
  logic [63:0] m_rt;

  // Expected entry from the current inputs: alignment as "address is a multiple of access bytes".
  function automatic model_t model_entry();
    model_t          e;
    longint unsigned bytes;
    logic            mem;
    bytes        = 64'd1 << bus.in_mem_size;
    mem          = bus.in_is_load || bus.in_is_store;
    e.mis        = mem && ((bus.in_result % bytes) != 0);
    e.result     = bus.in_result;
    e.rd         = bus.in_rd;
    e.we         = bus.in_writes_rd && (bus.in_rd != 0) && !e.mis;
    e.is_load    = bus.in_is_load && !e.mis;
    e.is_store   = bus.in_is_store && !e.mis;
    e.size       = bus.in_mem_size;
    e.store_data = bus.in_store_data;
    return e;
  endfunction

  task automatic drive_idle();
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_result     = '0;
    bus.in_rd         = '0;
    bus.in_writes_rd  = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_is_store   = 1'b0;
    bus.in_mem_size   = 2'd0;
    bus.in_store_data = '0;
    bus.in_is_branch  = 1'b0;
    bus.in_taken      = 1'b0;
    bus.in_target     = '0;
    bus.out_ready     = 1'b0;
  endtask

  task automatic drive_push(input logic [63:0] res, input logic [4:0] rd);
    drive_idle();
    bus.in_valid     = 1'b1;
    bus.in_result    = res;
    bus.in_rd        = rd;
    bus.in_writes_rd = 1'b1;
  endtask

  // One clock edge: update the model from the inputs held across it, end on the falling edge.
  task automatic advance();
    logic   acc, do_pop, enq;
    model_t e;
    acc    = bus.in_valid && (mq.size() < DEPTH) && !bus.flush;
    do_pop = (mq.size() > 0) && bus.out_ready;
    enq    = bus.in_writes_rd || bus.in_is_load || bus.in_is_store;
    e      = model_entry();
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_rv = 1'b0;
      m_rt = '0;
    end else if (bus.flush) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (acc && enq) mq.push_back(e);
      m_rv = acc && bus.in_is_branch && bus.in_taken;
      if (m_rv) m_rt = bus.in_target;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_push(64'h40, 5'd3);
    bus.in_is_branch = 1'b1;
    bus.in_taken     = 1'b1;
    bus.in_target    = 64'h1234;
    advance();
    drive_push(64'h48, 5'd4);
    advance();
    vectors++;
    if (bus.redirect_target !== 64'h1234) begin
      miscompares++;
      $display("FAIL pre_reset_target: got %h want 1234", bus.redirect_target);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(64'h50 + 64'(i), 5'd6);
      bus.in_is_branch = 1'b1;
      bus.in_taken     = 1'b1;
      advance();
    end
    reset = 1'b1;
    drive_idle();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_out: got valid=%b result=%h want 0/0", bus.out_valid, bus.out_result);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_target !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_redirect: got %b/%h want 0/0", bus.redirect_valid, bus.redirect_target);
    end
  endtask

  task automatic test_basic();
    drive_push(64'h10, 5'd5);
    bus.out_ready = 1'b1;
    advance();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h10 || bus.out_we !== 1'b1 || bus.out_rd !== 5'd5) begin
      miscompares++;
      $display("FAIL basic_add: got v=%b res=%h we=%b rd=%0d want 1/10/1/5",
               bus.out_valid, bus.out_result, bus.out_we, bus.out_rd);
    end
    advance();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive_push(64'hA1, 5'd1);
    advance();
    drive_push(64'hB2, 5'd2);
    advance();
    drive_push(64'hC3, 5'd3);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
    end
    advance();
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_result !== 64'hA1) begin
      miscompares++;
      $display("FAIL bp_pop_cycle: got ready=%b head=%h want 0/a1", bus.in_ready, bus.out_result);
    end
    advance();
    bus.out_ready = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_result !== 64'hB2) begin
      miscompares++;
      $display("FAIL bp_after_pop: got ready=%b head=%h want 1/b2", bus.in_ready, bus.out_result);
    end
    advance();
    drive_idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== (i == 0 ? 64'hB2 : 64'hC3)) begin
        miscompares++;
        $display("FAIL bp_order%0d: got v=%b res=%h", i, bus.out_valid, bus.out_result);
      end
      advance();
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_align();
    logic [63:0] addrs [3] = '{64'h1002, 64'h1004, 64'h1004};
    logic [1:0]  sizes [3] = '{2'd2, 2'd2, 2'd3};
    logic        mis   [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_push(addrs[i], 5'd7);
      bus.in_is_load   = (i != 2);
      bus.in_is_store  = (i == 2);
      bus.in_writes_rd = (i != 2);
      bus.in_mem_size  = sizes[i];
      bus.out_ready    = 1'b1;
      advance();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_misaligned !== mis[i]
          || bus.out_is_load !== (i == 1) || bus.out_is_store !== 1'b0
          || bus.out_we !== (i == 1) || bus.out_mem_size !== sizes[i]) begin
        miscompares++;
        $display("FAIL align%0d: got v=%b mis=%b ld=%b st=%b we=%b sz=%0d want mis=%b",
                 i, bus.out_valid, bus.out_misaligned, bus.out_is_load, bus.out_is_store,
                 bus.out_we, bus.out_mem_size, mis[i]);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    drive_idle();
    bus.in_valid     = 1'b1;
    bus.in_is_branch = 1'b1;
    bus.in_taken     = 1'b1;
    bus.in_target    = 64'h8000;
    bus.out_ready    = 1'b1;
    advance();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_target !== 64'h8000 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redirect_pulse: got rv=%b tgt=%h ov=%b want 1/8000/0",
               bus.redirect_valid, bus.redirect_target, bus.out_valid);
    end
    advance();
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_target !== 64'h8000) begin
      miscompares++;
      $display("FAIL redirect_end: got rv=%b tgt=%h want 0/8000", bus.redirect_valid, bus.redirect_target);
    end
    bus.in_valid  = 1'b1;
    bus.in_taken  = 1'b0;
    bus.in_target = 64'h9000;
    advance();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_target !== 64'h8000) begin
      miscompares++;
      $display("FAIL redirect_untaken: got rv=%b tgt=%h want 0/8000", bus.redirect_valid, bus.redirect_target);
    end
  endtask

  task automatic test_flush();
    drive_push(64'h90, 5'd9);
    advance();
    drive_push(64'hA0, 5'd10);
    bus.in_is_branch = 1'b1;
    bus.in_taken     = 1'b1;
    bus.in_target    = 64'hBEEF;
    advance();
    drive_push(64'hB0, 5'd11);
    bus.in_is_branch = 1'b1;
    bus.in_taken     = 1'b1;
    bus.in_target    = 64'hDEAD;
    bus.flush        = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.redirect_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle: got ready=%b ov=%b rv=%b want 0/1/1",
               bus.in_ready, bus.out_valid, bus.redirect_valid);
    end
    advance();
    drive_idle();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.redirect_valid !== 1'b0
        || bus.redirect_target !== 64'hBEEF) begin
      miscompares++;
      $display("FAIL flush_after: got ov=%b ready=%b rv=%b tgt=%h want 0/1/0/beef",
               bus.out_valid, bus.in_ready, bus.redirect_valid, bus.redirect_target);
    end
    drive_push(64'h55, 5'd0);
    advance();
    drive_push(64'h66, 5'd12);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_we !== 1'b0 || bus.out_result !== 64'h55 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_rd0: got ov=%b we=%b res=%h ready=%b want 1/0/55/1",
               bus.out_valid, bus.out_we, bus.out_result, bus.in_ready);
    end
    advance();
    drive_idle();
    bus.out_ready = 1'b1;
    advance();
    advance();
  endtask

  task automatic test_random();
    logic [204:0] got, exp;
    model_t       h;
    for (int n = 0; n < 800; n++) begin
      reset             = ($urandom_range(0, 99) != 0);
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.out_ready     = ($urandom_range(0, 2) != 0);
      bus.in_result     = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) bus.in_result[2:0] = 3'b000;
      bus.in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.in_writes_rd  = 1'($urandom);
      bus.in_is_load    = ($urandom_range(0, 2) == 0);
      bus.in_is_store   = ($urandom_range(0, 3) == 0);
      bus.in_mem_size   = 2'($urandom);
      bus.in_store_data = {$urandom, $urandom};
      bus.in_is_branch  = ($urandom_range(0, 3) == 0);
      bus.in_taken      = 1'($urandom);
      bus.in_target     = {$urandom, $urandom};
      #1;
      vectors++;
      if (bus.in_ready !== ((mq.size() < DEPTH) && !bus.flush)) begin
        miscompares++;
        $display("FAIL rand_in_ready[%0d]: got %b with %0d queued flush=%b", n, bus.in_ready, mq.size(), bus.flush);
      end
      got = {bus.out_valid, bus.out_result, bus.out_rd, bus.out_we, bus.out_is_load, bus.out_is_store,
             bus.out_mem_size, bus.out_store_data, bus.out_misaligned, bus.redirect_valid, bus.redirect_target};
      if (mq.size() > 0) begin
        h = mq[0];
        exp = {1'b1, h.result, h.rd, h.we, h.is_load, h.is_store, h.size, h.store_data, h.mis, m_rv, m_rt};
      end else begin
        exp = {140'b0, m_rv, m_rt};
      end
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rand_outputs[%0d]: got %h want %h", n, got, exp);
      end
      advance();
    end
    reset = 1'b1;
    drive_idle();
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    advance();
    advance();
    test_reset();
    test_basic();
    test_backpressure();
    test_align();
    test_redirect();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
